// File: rtl/round_timer.sv
// round_timer: prescaled seconds countdown with sticky expiry flag, remaining count and low-time warning
module round_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int WARN_AT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       time_f,
    input  logic [4:0] time_v,
    output logic       end_f,
    output logic [4:0] remaining,
    output logic       running,
    output logic       sec_tick,
    output logic       warn
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic            time_f_q;
    logic            start;
    logic            cancel;
    logic            tick;
    logic [PW-1:0]   pcnt;
    logic [4:0]      rem_dec;

    always_comb begin
        start   = time_f & ~time_f_q;
        cancel  = ~time_f & time_f_q;
        tick    = (state == RUN) && (pcnt == PW'(TICK_DIV - 1));
        rem_dec = (remaining != 5'd0) ? remaining - 5'd1 : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            time_f_q  <= 1'b0;
            pcnt      <= '0;
            end_f     <= 1'b0;
            remaining <= 5'd0;
            running   <= 1'b0;
            sec_tick  <= 1'b0;
            warn      <= 1'b0;
        end else begin
            time_f_q <= time_f;
            sec_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && time_v != 5'd0) begin
                        state     <= RUN;
                        remaining <= time_v;
                        pcnt      <= '0;
                        end_f     <= 1'b0;
                        running   <= 1'b1;
                        warn      <= int'(time_v) <= WARN_AT;
                    end else if (start) begin
                        state     <= DONE;
                        remaining <= 5'd0;
                        end_f     <= 1'b1;
                    end
                end
                RUN: begin
                    // cancel beats a coincident tick, including the final one
                    if (cancel) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        warn    <= 1'b0;
                    end else if (tick) begin
                        pcnt      <= '0;
                        sec_tick  <= 1'b1;
                        remaining <= rem_dec;
                        if (rem_dec == 5'd0) begin
                            state   <= DONE;
                            end_f   <= 1'b1;
                            running <= 1'b0;
                            warn    <= 1'b0;
                        end else begin
                            warn <= int'(rem_dec) <= WARN_AT;
                        end
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                DONE: begin
                    if (cancel) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_round_timer.sv
// tb_round_timer: vector table, directed countdown sequences and randomized run against a deadline model
module tb_round_timer;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       time_f;
    logic [4:0] time_v;
    logic       end_f;
    logic [4:0] remaining;
    logic       running;
    logic       sec_tick;
    logic       warn;

    int n_checks = 0;
    int n_fail   = 0;

    round_timer #(.TICK_DIV(TD), .WARN_AT(3)) dut (
        .clk(clk), .rst(rst), .time_f(time_f), .time_v(time_v),
        .end_f(end_f), .remaining(remaining), .running(running),
        .sec_tick(sec_tick), .warn(warn)
    );

    always #5 clk = ~clk;

    // Reference: remaining derived from elapsed cycles since the start edge
    int cyc = 0, m_start = 0, m_load = 0, m_rem = 0, m_end = 0;
    int m_run = 0, m_tick = 0, m_warn = 0, m_prev = 0;
    always @(posedge clk) begin
        int el;
        cyc = cyc + 1;
        m_tick = 0;
        if (rst) begin
            m_run = 0; m_end = 0; m_rem = 0; m_prev = 0;
        end else begin
            el = cyc - m_start;
            if (m_run != 0 && !time_f && m_prev != 0) begin
                m_run = 0;
            end else if (m_run != 0 && el % TD == 0) begin
                m_tick = 1;
                m_rem = m_load - el / TD;
                if (m_rem == 0) begin m_end = 1; m_run = 0; end
            end else if (m_run == 0 && time_f && m_prev == 0) begin
                if (time_v != 5'd0) begin
                    m_run = 1; m_load = int'(time_v); m_rem = m_load; m_start = cyc; m_end = 0;
                end else begin
                    m_end = 1; m_rem = 0;
                end
            end
            m_prev = int'(time_f);
        end
        m_warn = (m_run != 0 && m_rem > 0 && m_rem <= 3) ? 1 : 0;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int e_end, input int e_rem,
                             input int e_run, input int e_tick, input int e_warn);
        chk({tag, " end_f"}, int'(end_f), e_end);
        chk({tag, " remaining"}, int'(remaining), e_rem);
        chk({tag, " running"}, int'(running), e_run);
        chk({tag, " sec_tick"}, int'(sec_tick), e_tick);
        chk({tag, " warn"}, int'(warn), e_warn);
    endtask

    task automatic step(input int r, input int f, input int v);
        rst = r[0]; time_f = f[0]; time_v = v[4:0];
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int r, f, v;
        int e_end, e_rem, e_run, e_tick, e_warn;
    } vec_t;

    vec_t tbl[21];

    initial begin
        int ff, vv, rr;
        tbl[0]  = '{1, 1, 7, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 7, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 7, 0, 7, 1, 0, 0};
        tbl[3]  = '{0, 1, 9, 0, 7, 1, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 0, 1, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[10] = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[11] = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[12] = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[13] = '{0, 1, 1, 1, 0, 0, 1, 0};
        tbl[14] = '{0, 1, 1, 1, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 1, 1, 0, 0, 0, 0};
        tbl[16] = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[17] = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[18] = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[19] = '{0, 1, 1, 0, 1, 1, 0, 1};
        tbl[20] = '{0, 1, 1, 1, 0, 0, 1, 0};
        rst = 1'b1; time_f = 1'b0; time_v = 5'd0;
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].v);
            check_all($sformatf("vec%0d", i), tbl[i].e_end, tbl[i].e_rem,
                      tbl[i].e_run, tbl[i].e_tick, tbl[i].e_warn);
        end

        // normal expiry with time_v=5; time_v wiggles afterwards and must be ignored
        step(0, 0, 5);
        for (int k = 0; k <= 22; k++) begin
            step(0, 1, k == 0 ? 5 : k);
            check_all($sformatf("expire k%0d", k), k >= 20 ? 1 : 0,
                      k >= 20 ? 0 : 5 - k / TD, k < 20 ? 1 : 0,
                      (k > 0 && k % TD == 0 && k <= 20) ? 1 : 0,
                      (k >= 8 && k <= 19) ? 1 : 0);
        end

        // cancel at N+10 holds remaining=3
        step(0, 0, 5);
        chk("done cancel end_f", int'(end_f), 1);
        for (int k = 0; k <= 16; k++) begin
            step(0, k < 10 ? 1 : 0, 5);
            if (k >= 10) check_all($sformatf("cancel k%0d", k), 0, 3, 0, 0, 0);
        end

        // cancel collides with the tick at N+8 (which would be the final one)
        for (int k = 0; k <= 12; k++) begin
            step(0, k < 8 ? 1 : 0, 2);
            if (k == 4) chk("coll first tick", int'(sec_tick), 1);
            if (k >= 8) check_all($sformatf("coll k%0d", k), 0, 1, 0, 0, 0);
        end

        // randomized traffic against the deadline model
        ff = 0;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom % 250 == 0) ? 1 : 0;
            if ($urandom % 23 == 0) ff = 1 - ff;
            vv = ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 6);
            step(rr, ff, vv);
            check_all($sformatf("rand%0d", i), m_end, m_rem, m_run, m_tick, m_warn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/round_timer.md
# round_timer

Countdown timer feeding the game-logic block's `end_f` input. The game logic raises `time_f` to start a round and drives `time_v` with the allowed number of seconds. This block counts the seconds down with a clock prescaler and flags expiry on `end_f`. It also exports the remaining seconds and a low-time warning for the display stage.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per counted second. Legal range is 2 or more. Benches use 4.
- `WARN_AT`, default 3: `warn` is high while `remaining` is nonzero and at most this value.

Ports:
- `clk`, input, 1: system clock. The block has one clock; all state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `time_f`, input, 1: round-active level from the game logic. A rising edge starts the timer. A falling edge cancels it.
- `time_v`, input, 5: seconds to load. Sampled only on the start edge.
- `end_f`, output, 1: time expired. Sticky.
- `remaining`, output, 5: whole seconds left.
- `running`, output, 1: countdown in progress.
- `sec_tick`, output, 1: one-cycle pulse at each second decrement.
- `warn`, output, 1: low-time indication.

## Operation
- Edge detect uses registered `time_f_q`, which resets to 0.
  - `start = time_f & ~time_f_q`
  - `cancel = ~time_f & time_f_q`
- The prescaler `pcnt` has width `$clog2(TICK_DIV)`. It runs only while in RUN.
- `tick` is asserted when `pcnt == TICK_DIV-1` in RUN. On `tick`, `pcnt` wraps to 0.
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - `start` with `time_v != 0`: load `remaining = time_v`, set `pcnt = 0`, clear `end_f`, go to RUN.
  - `start` with `time_v == 0`: set `end_f = 1`, set `remaining = 0`, go to DONE.
- RUN:
  - On `tick`, `remaining` decrements and `sec_tick` pulses.
  - If `remaining` was 1 at the `tick`: `remaining` goes to 0, `end_f` goes to 1, next state is DONE.
  - `cancel`: go to IDLE. `remaining` holds its value and `end_f` stays 0.
  - `start` cannot occur in RUN without a prior `cancel`. The edge detector guarantees this.
- DONE:
  - `end_f` holds 1 and `remaining` holds 0.
  - `cancel` moves to IDLE with `end_f` still 1.
  - `end_f` clears only on the next `start` or on `rst`.
- Output definitions:
  - `running = (state == RUN)`
  - `warn = running && remaining != 0 && remaining <= WARN_AT`
- Arithmetic:
  - `remaining` is 5-bit unsigned and never decrements below 0. An underflow guard is required.
  - The `time_v` range is 0–31.

## Timing
- Reset values, all at the first edge with `rst` high:
  - state = IDLE
  - `end_f = 0`, `remaining = 0`, `running = 0`, `sec_tick = 0`, `warn = 0`
  - `pcnt = 0`, `time_f_q = 0`
- `rst` overrides every other input, including mid-countdown. After `rst` the timer needs a new rising edge of `time_f`. If `time_f` is already high when `rst` releases, that counts as a rising edge because `time_f_q` = 0.
- Start latency: with `time_f` sampled high at edge N and low at N-1, `running` and `remaining = time_v` are visible after edge N.
- The first `sec_tick` registers at edge N+TICK_DIV. Decrement k registers at edge N+k·TICK_DIV.
- `end_f` rises at edge N+time_v·TICK_DIV, coincident with the final `sec_tick` and with `remaining` reaching 0. `running` falls at the same edge.
- With `time_v = 0`, `end_f` rises at edge N and `sec_tick` never pulses.
- Cancel landing in the same cycle as a `tick`: cancel wins. No decrement, no `sec_tick`, no `end_f`.
- Cancel landing in the same cycle as the final `tick`: cancel wins and `end_f` stays 0.
- `sec_tick` is registered, exactly 1 cycle wide, and only produced in RUN.
- `time_v` changes after the start edge are ignored.

## Test plan
All scenarios use `TICK_DIV=4` and `WARN_AT=3`.
- Reset: hold `rst` 2 cycles with `time_f=1`, then release. Required: all outputs 0 during reset. After release, `running=1` and `remaining` = current `time_v`.
- Normal expiry: `time_v=5`, `time_f` rising at edge N.
  - `remaining` = 5, 4, 3, 2, 1, 0 at edges N, N+4, N+8, N+12, N+16, N+20.
  - `sec_tick` pulses 5 times.
  - `warn` is high from N+8 to N+19.
  - `end_f` rises at N+20 and stays high while `time_f` stays high.
- Cancel: `time_v=5`, drop `time_f` at edge N+10. Required: `running=0`, `remaining=3` held, `end_f=0`, no further `sec_tick`.
- Cancel/tick collision: `time_v=2`, drop `time_f` exactly at edge N+8. Required: `end_f` stays 0, `remaining=1`, no `sec_tick` at N+8.
- Zero load: `time_v=0`, rising `time_f` at edge N. Required: `end_f=1` at N, `running=0`, no `sec_tick`.
- Restart clears `end_f`: after an expiry, lower `time_f` and confirm `end_f` still 1. Raise `time_f` with `time_v=1`. Required: `end_f` clears at the start edge and re-asserts 4 cycles later.
